// File: rtl/div_sched.sv
// Sequencing controller between EX and an iterative radix-2 divider core.
// Optional macro DIV_ZERO_FAST_EN: zero divisor bypasses the core and completes in one cycle.
module div_sched #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MAX_CYCLES = 40,
    parameter int unsigned CNT_W      = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               div_req_i,
    input  logic               div_signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               flush_i,
    input  logic               hold_i,
    input  logic               core_ready_i,
    input  logic [2*WIDTH-1:0] core_result_i,
    output logic               core_start_o,
    output logic               core_signed_o,
    output logic [WIDTH-1:0]   core_op1_o,
    output logic [WIDTH-1:0]   core_op2_o,
    output logic               core_annul_o,
    output logic               stall_div_o,
    output logic               hilo_we_o,
    output logic [WIDTH-1:0]   hi_o,
    output logic [WIDTH-1:0]   lo_o,
    output logic               err_o,
    output logic [CNT_W-1:0]   cycles_o
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic             signed_q, signed_d;
    logic [WIDTH-1:0] op1_q, op1_d;
    logic [WIDTH-1:0] op2_q, op2_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            signed_q <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            signed_q <= signed_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        signed_d     = signed_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        stall_c      = 1'b0;
        core_start_o = 1'b0;
        core_annul_o = 1'b0;
        hilo_we_o    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (div_req_i && !flush_i) begin
                    stall_c  = 1'b1;
                    signed_d = div_signed_i;
                    op1_d    = opdata1_i;
                    op2_d    = opdata2_i;
                    cnt_d    = '0;
`ifdef DIV_ZERO_FAST_EN
                    if (opdata2_i == '0) begin
                        hi_d    = opdata1_i;
                        lo_d    = '1;
                        state_d = StDone;
                    end else begin
                        state_d = StBusy;
                    end
`else
                    state_d  = StBusy;
`endif
                end
            end
            StBusy: begin
                core_start_o = 1'b1;
                stall_c      = 1'b1;
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                // Priority: flush, then core completion, then watchdog.
                if (flush_i) begin
                    core_annul_o = 1'b1;
                    state_d      = StIdle;
                end else if (core_ready_i) begin
                    hi_d    = core_result_i[2*WIDTH-1:WIDTH];
                    lo_d    = core_result_i[WIDTH-1:0];
                    state_d = StDone;
                end else if (cnt_q == CNT_W'(MAX_CYCLES)) begin
                    core_annul_o = 1'b1;
                    err_d        = 1'b1;
                    state_d      = StIdle;
                end
            end
            StDone: begin
                hilo_we_o = !hold_i && !flush_i;
                if (!hold_i || flush_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // The request-cycle stall is combinational from inputs, so mask it during reset.
    assign stall_div_o   = stall_c && !rst;
    assign core_signed_o = signed_q;
    assign core_op1_o    = op1_q;
    assign core_op2_o    = op2_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
    assign err_o         = err_q;
    assign cycles_o      = cnt_q;

endmodule

// File: doc/div_sched.md
Name: div_sched

Overview:
- Sequencing controller that sits between the EX stage and the iterative radix-2 divider core.
- Latches operands on a DIV/DIVU request and holds them stable for the whole operation.
- Drives the core start/signed/annul handshake, stalls the pipeline until the quotient and remainder are ready, and issues a single HI/LO write when the instruction retires from EX.
- Includes a watchdog that aborts a hung divide.

Parameters:
- WIDTH, 32, operand width; core result is 2*WIDTH.
- MAX_CYCLES, 40, BUSY cycles allowed before watchdog abort.
- CNT_W, 6, width of cycle counter; must hold MAX_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- div_req_i  in  1  EX holds a DIV/DIVU instruction
- div_signed_i  in  1  1=DIV, 0=DIVU; sampled with operands
- opdata1_i  in  WIDTH  dividend
- opdata2_i  in  WIDTH  divisor
- flush_i  in  1  exception/flush kills the EX instruction
- hold_i  in  1  downstream stall; EX cannot advance this cycle
- core_ready_i  in  1  divider core done, result valid
- core_result_i  in  2*WIDTH  {remainder, quotient}
- core_start_o  out  1  core start level
- core_signed_o  out  1  core signed mode
- core_op1_o  out  WIDTH  latched dividend
- core_op2_o  out  WIDTH  latched divisor
- core_annul_o  out  1  abort core operation
- stall_div_o  out  1  freeze IF/ID/EX
- hilo_we_o  out  1  one-cycle HI/LO write strobe
- hi_o  out  WIDTH  remainder
- lo_o  out  WIDTH  quotient
- err_o  out  1  sticky watchdog error
- cycles_o  out  CNT_W  BUSY cycles of last/current op, saturating

Behaviour:
- Reset: state=IDLE; all registers zero; err_o=0. Every output is 0 while rst is high.
- Reset mid-operation returns to IDLE immediately; no hilo_we_o is issued.
- States IDLE, BUSY, DONE. State and all registers update on the clk rising edge.
- IDLE:
  - div_req_i & !flush_i: latch opdata1/2 and div_signed_i, clear counter, go to BUSY.
  - stall_div_o = div_req_i & !flush_i (combinational) in the request cycle.
- BUSY:
  - core_start_o=1; core_signed_o, core_op1_o, core_op2_o are the latched values and stay constant.
  - stall_div_o=1; counter increments and saturates at 2^CNT_W-1.
  - core_ready_i: capture result (hi = [2W-1:W], lo = [W-1:0]), go to DONE. core_start_o drops the next cycle.
  - flush_i: core_annul_o=1 this cycle (combinational), go to IDLE. flush wins over a simultaneous core_ready_i.
  - counter == MAX_CYCLES without ready: core_annul_o=1, err_o set (sticky until rst), go to IDLE, no write.
- DONE:
  - stall_div_o=0; hi_o/lo_o hold the captured values.
  - hilo_we_o = !hold_i & !flush_i.
  - Go to IDLE when !hold_i or flush_i. With hold_i & !flush_i, stay in DONE and do not restart.
- Operand inputs are ignored outside the IDLE request cycle.
- Back-to-back divides: a new request is accepted in the IDLE cycle after DONE.
- hi_o/lo_o keep their last values in IDLE.
- Latency: request cycle + BUSY cycles (core-dependent) + 1 DONE cycle.
  - With a 33-cycle core: stall is asserted for 1+33 cycles.
  - hilo_we_o asserts in the DONE cycle, which is the first unstalled cycle.

Optional Feature:
- Macro DIV_ZERO_FAST_EN.
- Defined:
  - IDLE request with opdata2_i==0 skips BUSY and goes straight to DONE.
  - hi = opdata1_i, lo = all ones; core_start_o is never raised.
  - stall_div_o stays asserted in the request cycle only.
  - cycles_o = 0.
- Undefined: a zero divisor runs through the core like any other operand.

Test Plan:
- Signed: DIV -7/2 -> core_signed_o=1 during BUSY; single hilo_we_o; lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; stall low in DONE.
- Unsigned: DIVU 100/7 with opdata inputs changed during BUSY -> core_op1/2_o stay 100/7; lo_o=14, hi_o=2.
- Flush: flush_i in the 10th BUSY cycle -> core_annul_o pulse for 1 cycle; IDLE next cycle; no hilo_we_o; a later DIVU 9/3 gives lo_o=3, hi_o=0.
- Hold: hold_i=1 for 3 cycles at DONE -> hilo_we_o stays 0 for 3 cycles, then 1 for exactly 1 cycle; stall_div_o=0 throughout.
- Watchdog: core_ready_i tied 0 -> after MAX_CYCLES=40, core_annul_o=1 and err_o=1 (sticky); rst clears err_o and all outputs asynchronously mid-cycle.
- DIV_ZERO_FAST_EN: DIVU 5/0 -> no core_start_o; DONE next cycle; hi_o=5, lo_o=0xFFFFFFFF. Without the macro, the core runs normally.
